// File: rtl/esp32_prog_bridge_if.sv
// Pin bundle between the FTDI/ESP32 board nets and the programming bridge.
// The slave modport is the bridge's view; master is the board or bench side.
`timescale 1ns/1ps
interface esp32_prog_bridge_if #(
   parameter int C_btn_width = 7
);
   logic                   ftdi_ndtr;
   logic                   ftdi_nrts;
   logic [C_btn_width-1:0] btn;
   logic                   spi_csn;
   logic                   spi_sclk;
   logic                   wifi_en;
   logic                   wifi_gpio0;
   logic                   strap_oe;
   logic                   strap_out;
   logic                   spi_miso;
   logic                   spi_miso_oe;
   logic                   prog_active;
   logic                   user_programn;

   modport slave (
      input  ftdi_ndtr, ftdi_nrts, btn, spi_csn, spi_sclk,
      output wifi_en, wifi_gpio0, strap_oe, strap_out,
             spi_miso, spi_miso_oe, prog_active, user_programn
   );

   modport master (
      output ftdi_ndtr, ftdi_nrts, btn, spi_csn, spi_sclk,
      input  wifi_en, wifi_gpio0, strap_oe, strap_out,
             spi_miso, spi_miso_oe, prog_active, user_programn
   );
endinterface

// File: rtl/esp32_prog_bridge.sv
// FTDI DTR/RTS to ESP32 EN/IO0 bridge with strap-hold FSM, oversampled SPI
// button readback and a multiboot PROGRAMN combo detector.
//
// state | meaning
// IDLE  | no programming sequence; timer saturated, straps released
// HOLD  | GPIO2 strap driven, timer counting up to all-ones
// RUN   | one-cycle release strobe before returning to IDLE
`timescale 1ns/1ps
module esp32_prog_bridge #(
   parameter int                     C_sync_stages   = 2,
   parameter int                     C_release_bits  = 17,
   parameter int                     C_btn_width     = 7,
   parameter int                     C_spi_bits      = 8,
   parameter logic [C_btn_width-1:0] C_combo_mask    = 7'b0000011,
   parameter logic [C_btn_width-1:0] C_combo_value   = 7'b0000010,
   parameter int                     C_programn_bits = 8
) (
   input  logic               clk_25mhz,
   input  logic               rstn,
   esp32_prog_bridge_if.slave bus
);

   localparam int C_sync_width = C_btn_width + 4;
   // ndtr, nrts and csn idle high; sclk and buttons reset low
   localparam logic [C_sync_width-1:0] C_sync_rst = {3'b111, {(C_btn_width+1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   logic [C_sync_width-1:0]    sync_q [C_sync_stages];
   logic [C_sync_width-1:0]    sync_in;
   logic [C_sync_width-1:0]    sync_out;
   logic                       dtr;
   logic                       rts;
   logic                       csn_s;
   logic                       sclk_s;
   logic [C_btn_width-1:0]     btn_s;

   logic                       dtr_d;
   logic                       rts_d;
   logic                       dec_en;
   logic                       dec_io0;
   logic                       en_q;
   logic                       io0_q;
   logic                       gpio0_q;
   logic                       trig;

   state_t                     state_q;
   state_t                     state_n;
   logic [C_release_bits-1:0]  timer_q;
   logic [C_release_bits-1:0]  timer_n;

   logic [C_spi_bits-1:0]      frame_q;
   logic                       sclk_d;
   logic                       sclk_fall;
   logic                       miso_q;
   logic                       miso_oe_q;

   logic                       combo;
   logic [C_programn_bits-1:0] pgm_cnt_q;
   logic                       programn_q;

   assign sync_in = {bus.ftdi_ndtr, bus.ftdi_nrts, bus.spi_csn, bus.spi_sclk, bus.btn};

   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < C_sync_stages; i++) sync_q[i] <= C_sync_rst;
      end else begin
         sync_q[0] <= sync_in;
         for (int i = 1; i < C_sync_stages; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[C_sync_stages-1];
   assign dtr      = sync_out[C_sync_width-1];
   assign rts      = sync_out[C_sync_width-2];
   assign csn_s    = sync_out[C_btn_width+1];
   assign sclk_s   = sync_out[C_btn_width];
   assign btn_s    = sync_out[C_btn_width-1:0];

   assign dec_en  = !(dtr && !rts);
   assign dec_io0 = !(!dtr && rts);
   // Only a (1,1) -> (1,0) transition starts a strap hold, so the trigger
   // fires on the same edge that registers en=0.
   assign trig    = dtr && !rts && dtr_d && rts_d;

   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         dtr_d   <= 1'b1;
         rts_d   <= 1'b1;
         en_q    <= 1'b1;
         io0_q   <= 1'b1;
         gpio0_q <= 1'b1;
      end else begin
         dtr_d   <= dtr;
         rts_d   <= rts;
         en_q    <= dec_en;
         io0_q   <= dec_io0;
         gpio0_q <= dec_io0 && btn_s[0];
      end
   end

   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         timer_q <= '1;
      end else begin
         state_q <= state_n;
         timer_q <= timer_n;
      end
   end

   always_comb begin
      state_n = state_q;
      timer_n = timer_q;
      case (state_q)
         S_IDLE: begin
            timer_n = '1;
            if (trig) begin
               state_n = S_HOLD;
               timer_n = '0;
            end
         end
         S_HOLD: begin
            // re-trigger takes precedence over terminal count
            if (trig) begin
               timer_n = '0;
            end else if (timer_q == '1) begin
               state_n = S_RUN;
            end else begin
               timer_n = timer_q + 1'b1;
            end
         end
         S_RUN: begin
            state_n = S_IDLE;
            timer_n = '1;
         end
         default: begin
            state_n = S_IDLE;
            timer_n = '1;
         end
      endcase
   end

   assign sclk_fall = sclk_d && !sclk_s;

   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         frame_q   <= '0;
         sclk_d    <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
      end else begin
         sclk_d    <= sclk_s;
         miso_oe_q <= !csn_s;
         miso_q    <= frame_q[C_spi_bits-1];
         // a deselect reloads the frame even if an sclk fall lands on the same cycle
         if (csn_s) begin
            frame_q <= {{(C_spi_bits-C_btn_width){1'b0}}, btn_s};
         end else if (sclk_fall) begin
            frame_q <= {frame_q[C_spi_bits-2:0], 1'b0};
         end
      end
   end

   assign combo = ((btn_s & C_combo_mask) == C_combo_value);

   // Release is seen on the very next edge; assertion waits for the MSB.
   always_ff @(posedge clk_25mhz or negedge rstn) begin
      if (!rstn) begin
         pgm_cnt_q  <= '0;
         programn_q <= 1'b1;
      end else begin
         if (!combo) begin
            pgm_cnt_q <= '0;
         end else if (pgm_cnt_q != '1) begin
            pgm_cnt_q <= pgm_cnt_q + 1'b1;
         end
         programn_q <= !(combo && pgm_cnt_q[C_programn_bits-1]);
      end
   end

   assign bus.wifi_en       = en_q;
   assign bus.wifi_gpio0    = gpio0_q;
   assign bus.prog_active   = (state_q == S_HOLD);
   assign bus.strap_oe      = (state_q == S_HOLD);
   assign bus.strap_out     = (state_q == S_HOLD) ? io0_q : 1'b1;
   assign bus.spi_miso      = miso_q;
   assign bus.spi_miso_oe   = miso_oe_q;
   assign bus.user_programn = programn_q;

endmodule
